// File: rtl/mem_bridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_bridge_pkg: shared state encoding and defaults for the bridge   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mem_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_CAP = 3'd2,
    WR_REQ = 3'd3,
    DONE   = 3'd4,
    FAULT  = 3'd5
  } bridge_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage
`default_nettype wire

// File: rtl/bridge_timeout_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bridge_timeout_counter: waitrequest cycle counter with terminal flag|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module bridge_timeout_counter #(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timeout_on
      localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);
      assign terminal = (count == TERM);
    end else begin : g_timeout_off
      assign terminal = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/avalon_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | avalon_mem_bridge: CPU load/store request to Avalon-MM master port  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module avalon_mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [3:0]  req_byteenable,
  input  logic [31:0] req_writedata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  bridge_state_t state;
  logic          timeout_hit;
  logic          cnt_enable;
  logic          cnt_clear;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^req_address[1:0];

  assign cnt_enable = waitrequest && ((state == RD_REQ) || (state == WR_REQ));
  assign cnt_clear  = (state == DONE);

  bridge_timeout_counter #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (timeout_hit)
  );

  // In IDLE the CPU must be stalled in the same cycle it raises a request.
  always_comb begin
    stall = 1'b1;
    case (state)
      IDLE:    stall = req_read | req_write;
      DONE:    stall = 1'b0;
      default: stall = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      byteenable <= '0;
      writedata  <= '0;
      rdata      <= '0;
      fault      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_read && req_write) begin
            fault <= 1'b1;
            state <= FAULT;
          end else if (req_read) begin
            address    <= {req_address[31:2], 2'b00};
            byteenable <= req_byteenable;
            read       <= 1'b1;
            state      <= RD_REQ;
          end else if (req_write) begin
            if (req_byteenable != 4'b0000) begin
              address    <= {req_address[31:2], 2'b00};
              byteenable <= req_byteenable;
              writedata  <= req_writedata;
              write      <= 1'b1;
              state      <= WR_REQ;
            end else begin
              state <= DONE;
            end
          end
        end
        RD_REQ: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            state <= RD_CAP;
          end else if (timeout_hit) begin
            read  <= 1'b0;
            fault <= 1'b1;
            state <= FAULT;
          end
        end
        RD_CAP: begin
          rdata <= readdata;
          state <= DONE;
        end
        WR_REQ: begin
          if (!waitrequest) begin
            write <= 1'b0;
            state <= DONE;
          end else if (timeout_hit) begin
            write <= 1'b0;
            fault <= 1'b1;
            state <= FAULT;
          end
        end
        DONE: begin
          read  <= 1'b0;
          write <= 1'b0;
          state <= IDLE;
        end
        FAULT: begin
          read  <= 1'b0;
          write <= 1'b0;
          fault <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avalon_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_avalon_mem_bridge: directed bench with cycle-level expectations  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_avalon_mem_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_address = '0;
  logic [3:0]  req_byteenable = '0;
  logic [31:0] req_writedata = '0;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;
  logic        stall;
  logic [31:0] rdata;
  logic        fault;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;

  int checks = 0;
  int failures = 0;

  avalon_mem_bridge #(
    .TIMEOUT_CYCLES (8),
    .CNT_W          (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_read       (req_read),
    .req_write      (req_write),
    .req_address    (req_address),
    .req_byteenable (req_byteenable),
    .req_writedata  (req_writedata),
    .stall          (stall),
    .rdata          (rdata),
    .fault          (fault),
    .address        (address),
    .read           (read),
    .write          (write),
    .byteenable     (byteenable),
    .writedata      (writedata),
    .waitrequest    (waitrequest),
    .readdata       (readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        stall;
    logic        read;
    logic        write;
    logic        fault;
    logic [31:0] rdata;
    bit          chk_bus;
    bit          chk_wd;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] m_rdata = '0;
  logic        m_fault = 1'b0;
  int          rd_run = 0, wr_run = 0, last_rd_run = 0, last_wr_run = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the expectation queue, plus strobe run lengths.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk({e.tag, ".stall"}, 32'(stall), 32'(e.stall));
      chk({e.tag, ".read"},  32'(read),  32'(e.read));
      chk({e.tag, ".write"}, 32'(write), 32'(e.write));
      chk({e.tag, ".fault"}, 32'(fault), 32'(e.fault));
      chk({e.tag, ".rdata"}, rdata, e.rdata);
      if (e.chk_bus) begin
        chk({e.tag, ".address"}, address, e.address);
        chk({e.tag, ".byteenable"}, 32'(byteenable), 32'(e.byteenable));
      end
      if (e.chk_wd) chk({e.tag, ".writedata"}, writedata, e.writedata);
    end
    if (read === 1'b1) rd_run++;
    else if (rd_run != 0) begin last_rd_run = rd_run; rd_run = 0; end
    if (write === 1'b1) wr_run++;
    else if (wr_run != 0) begin last_wr_run = wr_run; wr_run = 0; end
  end

  task automatic drive(input bit rr, input bit rw, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input bit wr, input logic [31:0] rd, input bit rst);
    @(posedge clk);
    #2;
    req_read = rr; req_write = rw; req_address = a; req_byteenable = be;
    req_writedata = wd; waitrequest = wr; readdata = rd; reset = rst;
  endtask

  task automatic expect_cyc(input string tag, input bit st, input bit r, input bit w,
                            input bit cb, input bit cw, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
    exp_t e;
    e.tag = tag; e.stall = st; e.read = r; e.write = w; e.fault = m_fault;
    e.rdata = m_rdata; e.chk_bus = cb; e.chk_wd = cw;
    e.address = {a[31:2], 2'b00}; e.byteenable = be; e.writedata = wd;
    expq.push_back(e);
  endtask

  task automatic idle(input string tag);
    drive(0, 0, '0, '0, '0, 0, '0, 0);
    expect_cyc(tag, 0, 0, 0, 0, 0, '0, '0, '0);
  endtask

  // Read: stall through cycle W+2, read during cycles 1..W+1, data returned in cycle W+2.
  task automatic do_read(input string tag, input logic [31:0] a, input logic [3:0] be,
                         input int w, input logic [31:0] data);
    for (int k = 0; k <= w + 3; k++) begin
      drive(1, 0, a, be, '0, (k >= 1 && k <= w), (k == w + 2) ? data : (32'hBAD0_0000 | 32'(k)), 0);
      if (k == w + 3) m_rdata = data;
      expect_cyc(tag, k <= w + 2, (k >= 1 && k <= w + 1), 0, (k >= 1 && k <= w + 1), 0, a, be, '0);
    end
    idle({tag, ".idle"});
  endtask

  // Write: stall through cycle W+1, write during cycles 1..W+1; empty byteenable skips the bus.
  task automatic do_write(input string tag, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input int w);
    if (be == 4'b0000) begin
      for (int k = 0; k <= 1; k++) begin
        drive(0, 1, a, be, wd, 0, '0, 0);
        expect_cyc(tag, k == 0, 0, 0, 0, 0, '0, '0, '0);
      end
    end else begin
      for (int k = 0; k <= w + 2; k++) begin
        drive(0, 1, a, be, wd, (k >= 1 && k <= w), '0, 0);
        expect_cyc(tag, k <= w + 1, 0, (k >= 1 && k <= w + 1), (k >= 1 && k <= w + 1),
                   (k >= 1 && k <= w + 1), a, be, wd);
      end
    end
    idle({tag, ".idle"});
  endtask

  // Reset applied for one edge; afterwards every output is back at zero.
  task automatic reset_pulse(input string tag, input bit st_before, input bit r_before, input bit w_before);
    drive(req_read, req_write, req_address, req_byteenable, req_writedata, waitrequest, '0, 1);
    expect_cyc({tag, ".pre"}, st_before, r_before, w_before, 0, 0, '0, '0, '0);
    m_fault = 1'b0;
    m_rdata = '0;
    drive(0, 0, '0, '0, '0, 0, '0, 0);
    expect_cyc({tag, ".post"}, 0, 0, 0, 1, 1, '0, '0, '0);
  endtask

  initial begin
    drive(0, 0, '0, '0, '0, 0, '0, 1);
    drive(0, 0, '0, '0, '0, 0, '0, 1);
    expect_cyc("reset", 0, 0, 0, 1, 1, '0, '0, '0);
    drive(0, 0, '0, '0, '0, 0, '0, 0);
    expect_cyc("reset_rel", 0, 0, 0, 1, 1, '0, '0, '0);

    do_read("rd0", 32'h1000_0006, 4'b1111, 0, 32'hDEAD_BEEF);
    chk("lit_rd0_rdata", rdata, 32'hDEAD_BEEF);
    chk("lit_rd0_addr", address, 32'h1000_0004);
    chk("lit_rd0_readlen", 32'(last_rd_run), 32'd1);

    do_write("wr3", 32'h2000_0010, 4'b1100, 32'h1234_0000, 3);
    chk("lit_wr3_writelen", 32'(last_wr_run), 32'd4);
    chk("lit_wr3_wd", writedata, 32'h1234_0000);

    do_read("rd2", 32'h3000_0103, 4'b0011, 2, 32'h0000_A5A5);
    chk("lit_rd2_addr", address, 32'h3000_0100);
    do_write("wr_be0", 32'h4000_0000, 4'b0000, 32'hFFFF_FFFF, 0);
    do_write("wr0", 32'h5000_0008, 4'b0001, 32'h0000_0077, 0);

    // Read and write together: fault, stall held, no strobes.
    drive(1, 1, 32'h6000_0000, 4'b1111, '0, 0, '0, 0);
    expect_cyc("both", 1, 0, 0, 0, 0, '0, '0, '0);
    m_fault = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 32'h6000_0000, 4'b1111, '0, 0, '0, 0);
      expect_cyc("both_flt", 1, 0, 0, 0, 0, '0, '0, '0);
    end
    chk("lit_both_fault", 32'(fault), 32'd1);
    reset_pulse("both_rst", 1, 0, 0);

    // Stuck waitrequest on a read times out after 8 strobe cycles.
    for (int k = 0; k <= 12; k++) begin
      drive(1, 0, 32'h7000_0004, 4'b1111, '0, k >= 1, '0, 0);
      if (k == 9) m_fault = 1'b1;
      expect_cyc("tmo", 1, (k >= 1 && k <= 8), 0, (k >= 1 && k <= 8), 0, 32'h7000_0004, 4'b1111, '0);
    end
    chk("lit_tmo_readlen", 32'(last_rd_run), 32'd8);
    reset_pulse("tmo_rst", 1, 0, 0);

    // Reset while a write is stuck in waitrequest, then a normal read.
    for (int k = 0; k <= 2; k++) begin
      drive(0, 1, 32'h8000_0020, 4'b1111, 32'hCAFE_F00D, k >= 1, '0, 0);
      expect_cyc("wr_rst", k <= 2, 0, k >= 1, k >= 1, k >= 1, 32'h8000_0020, 4'b1111, 32'hCAFE_F00D);
    end
    reset_pulse("wr_rst", 1, 0, 1);
    do_read("rd_after", 32'h9000_0040, 4'b0110, 1, 32'h1357_9BDF);
    chk("lit_rd_after_rdata", rdata, 32'h1357_9BDF);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/avalon_mem_bridge.md
Name: avalon_mem_bridge

Overview:
- Sits directly downstream of the CPU's data-selection/endian-conversion stage and drives the Avalon memory-mapped master port.
- Takes a word-aligned address, byteenable and write data, plus a read or write request, from that stage.
- Runs the Avalon handshake, including waitrequest, and holds bus signals stable until the request is accepted.
- Returns captured read data and a stall signal to the CPU; flags a fault on bus timeout or an illegal request.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles in RD_REQ/WR_REQ with waitrequest high before FAULT; 0 disables the timeout.
- CNT_W, 16: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_read  input  1  read request, level; held by the CPU while stall=1
- req_write  input  1  write request, level; held by the CPU while stall=1
- req_address  input  32  byte address; bits [1:0] ignored
- req_byteenable  input  4  lane enables
- req_writedata  input  32  lane-ordered write data
- stall  output  1  CPU must hold state and inputs while 1
- rdata  output  32  last captured read word (raw lanes)
- fault  output  1  sticky error flag
- address  output  32  Avalon address; bits [1:0] always 0
- read  output  1  Avalon read
- write  output  1  Avalon write
- byteenable  output  4  Avalon byteenable
- writedata  output  32  Avalon writedata
- waitrequest  input  1  Avalon waitrequest
- readdata  input  32  Avalon readdata; valid the cycle after read=1 with waitrequest=0

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high. Everything updates on the posedge of clk.
- Reset values: state=IDLE; read=0; write=0; address=0; byteenable=0; writedata=0; rdata=0; fault=0; counter=0.
- States: IDLE, RD_REQ, RD_CAP, WR_REQ, DONE, FAULT.
- IDLE:
  - stall = req_read | req_write (combinational).
  - req_read only: register {req_address[31:2],2'b00}, req_byteenable → RD_REQ.
  - req_write only, byteenable≠0: also register req_writedata → WR_REQ.
  - req_write, byteenable=0000: no bus cycle → DONE.
  - req_read and req_write both high: fault←1 → FAULT.
- RD_REQ:
  - read=1, stall=1, address/byteenable held.
  - waitrequest=0 → RD_CAP.
  - Otherwise counter++.
- RD_CAP:
  - read=0, stall=1; rdata←readdata at the end of the cycle → DONE.
- WR_REQ:
  - write=1, stall=1, address/byteenable/writedata held.
  - waitrequest=0 → DONE; otherwise counter++.
- DONE:
  - stall=0, counter←0, read=write=0 → IDLE unconditionally.
  - Requests seen in DONE belong to the completed transaction and are ignored.
- FAULT:
  - stall=1, read=write=0, fault=1; leaves only on reset.
- Timeout:
  - When TIMEOUT_CYCLES≠0 and counter reaches TIMEOUT_CYCLES-1 while waitrequest=1: fault←1 → FAULT.
  - The bus strobe drops on the next edge.
- Latency with zero wait states:
  - Read: request seen at cycle 0; stall=0 and rdata valid at cycle 3.
  - Write: stall=0 at cycle 2.
  - Each waitrequest cycle adds 1.
- read and write are never high together; Avalon outputs only change in IDLE/DONE or on acceptance.
- rdata is stable outside RD_CAP updates; it is raw lane data, with no endian swap or extension.
- Reset mid-transaction: the bus strobe drops on the next edge, the state goes to IDLE, and fault clears.

Decomposition:
- Shared package mem_bridge_pkg: state enum bridge_state_t (6 encodings, 3 bits) and the default TIMEOUT_CYCLES constant.
- One sub-module, bridge_timeout_counter: clear, enable and terminal-count compare, parameterised by CNT_W/TIMEOUT_CYCLES.

Test Plan:
- Read, zero wait: req_read, req_address=0x1000_0006, waitrequest=0, readdata=0xDEADBEEF → address=0x1000_0004, read high 1 cycle, stall low at cycle 3, rdata=0xDEADBEEF.
- Write with 3 wait states: req_write, req_byteenable=4'b1100, req_writedata=0x12340000 → write high 4 cycles with stable outputs, stall low 5 cycles after request.
- Write with byteenable=0000 → no read/write strobe, stall low at cycle 1.
- req_read and req_write together → fault=1, stall stays 1, no bus strobe; reset clears fault.
- Timeout: TIMEOUT_CYCLES=8, waitrequest stuck high on a read → read high for exactly 8 cycles, then FAULT, fault=1.
- Reset asserted during WR_REQ with waitrequest=1 → write=0 next edge, IDLE; a following read completes normally.
